// File: rtl/result_drain_reader.sv
// Drains the dotProduct output SRAM word by word into a valid/ready stream.
// Optional running checksum of accepted elements: define RESULT_DRAIN_CHECKSUM_EN.
module result_drain_reader #(
  parameter int unsigned Addr_Width     = 4,
  parameter int unsigned Ram_Depth      = 1 << Addr_Width,
  parameter int unsigned Para_Deg       = 1,
  parameter int unsigned Data_Width_Out = 16,
  parameter int unsigned Nums_Words     = Ram_Depth / Para_Deg
) (
  input  logic                                clk,
  input  logic                                Drain_reset,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                rd_en,
  output logic [Addr_Width-1:0]               rd_addr,
  input  logic [Para_Deg*Data_Width_Out-1:0]  rd_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [Para_Deg*Data_Width_Out-1:0]  out_data,
  output logic [Addr_Width:0]                 out_index,
  output logic                                out_last,
  output logic [Data_Width_Out-1:0]           checksum
);

  localparam int unsigned WordW = Para_Deg * Data_Width_Out;
  localparam int unsigned CntW  = Addr_Width + 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(Nums_Words - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StFlush, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CntW-1:0] emit_cnt_q, emit_cnt_d;
  logic            inflight_q;
  logic [Addr_Width-1:0] rd_addr_q;
  logic [WordW-1:0] mem_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      count_q;
  logic            push, pop;
  logic [2:0]      occ;

  assign push      = inflight_q;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem_q[rd_ptr_q];
  assign out_index = emit_cnt_q;
  assign out_last  = out_valid && (emit_cnt_q == LastIdx);
  assign rd_addr   = rd_en ? issue_cnt_q[Addr_Width-1:0] : rd_addr_q;

  // Slots committed after this edge; counting the pop keeps full rate at 2 entries.
  assign occ = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    emit_cnt_d  = emit_cnt_q;
    rd_en       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    if (pop) emit_cnt_d = emit_cnt_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        issue_cnt_d = '0;
        emit_cnt_d  = '0;
        if (start) state_d = StIssue;
      end
      StIssue: begin
        busy  = 1'b1;
        rd_en = (occ < 3'd2);
        if (rd_en) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LastIdx) state_d = StFlush;
        end
      end
      StFlush: begin
        busy = 1'b1;
        if (pop && (emit_cnt_q == LastIdx)) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Drain_reset) begin
      state_q     <= StIdle;
      issue_cnt_q <= '0;
      emit_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      rd_addr_q   <= '0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      emit_cnt_q  <= emit_cnt_d;
      inflight_q  <= rd_en;
      if (rd_en) rd_addr_q <= issue_cnt_q[Addr_Width-1:0];
      if (push) begin
        mem_q[wr_ptr_q] <= rd_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef RESULT_DRAIN_CHECKSUM_EN
  logic [Data_Width_Out-1:0] cksum_q, word_sum;

  always_comb begin
    word_sum = '0;
    for (int k = 0; k < int'(Para_Deg); k++) begin
      word_sum = word_sum + out_data[k*Data_Width_Out +: Data_Width_Out];
    end
  end

  always_ff @(posedge clk) begin
    if (Drain_reset) begin
      cksum_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      cksum_q <= '0;
    end else if (pop) begin
      cksum_q <= cksum_q + word_sum;
    end
  end

  assign checksum = cksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_result_drain_reader.sv
// Directed bench for result_drain_reader: cycle table for a full drain plus
// backpressure, restart, mid-run reset and a two-element-per-word instance.
module tb_result_drain_reader;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic        busy, done, rd_en, out_valid, out_last;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data = '0;
  logic [15:0] out_data;
  logic [4:0]  out_index;
  logic [15:0] checksum;

  logic        b_start, b_ready;
  logic        b_busy, b_done, b_rd_en, b_out_valid, b_out_last;
  logic [3:0]  b_rd_addr;
  logic [31:0] b_rd_data = '0;
  logic [31:0] b_out_data;
  logic [4:0]  b_out_index;
  logic [15:0] b_checksum;

`ifdef RESULT_DRAIN_CHECKSUM_EN
  localparam logic [15:0] ExpCkA = 16'd376;
  localparam logic [15:0] ExpCkB = 16'd120;
`else
  localparam logic [15:0] ExpCkA = 16'd0;
  localparam logic [15:0] ExpCkB = 16'd0;
`endif

  always #5 clk = ~clk;

  result_drain_reader #(.Addr_Width(4)) u_dut (
    .clk(clk), .Drain_reset(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .checksum(checksum)
  );

  result_drain_reader #(.Addr_Width(4), .Para_Deg(2)) u_dut_b (
    .clk(clk), .Drain_reset(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .out_valid(b_out_valid),
    .out_ready(b_ready), .out_data(b_out_data), .out_index(b_out_index),
    .out_last(b_out_last), .checksum(b_checksum)
  );

  // SRAM models with one cycle of read latency
  always @(posedge clk) if (rd_en) rd_data <= 16'(3 * int'(rd_addr) + 1);
  always @(posedge clk)
    if (b_rd_en) b_rd_data <= {16'(2 * int'(b_rd_addr) + 1), 16'(2 * int'(b_rd_addr))};

  typedef struct {
    logic        start;
    logic        ready;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic        out_valid;
    logic [4:0]  out_index;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs [21];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input bit bp, input int restart_at, input int reset_after);
    int exp_idx = 0, done_cnt = 0, issued = 0, max_out = 0, cyc = 0, post = 0;
    bit stalled = 1'b0, hit_reset = 1'b0, finished = 1'b0;
    logic [15:0] hold_d = '0;
    logic [4:0]  hold_i = '0;
    logic [3:0]  pat = 4'b1001;
    start = 1'b1;
    tick;
    while (!finished && cyc < 400) begin
      out_ready = bp ? pat[cyc % 4] : 1'b1;
      start = 1'b0;
      #1;
      if (rd_en) issued++;
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_hold", 32'({out_index, out_data}), 32'({hold_i, hold_d}));
      end
      stalled = 1'b0;
      if (out_valid && out_ready) begin
        chk("idx", 32'(out_index), 32'(exp_idx));
        chk("data", 32'(out_data), 32'(3 * exp_idx + 1));
        chk("last", 32'(out_last), 32'(exp_idx == 15));
        if (exp_idx == restart_at) start = 1'b1;
        if (exp_idx == reset_after) hit_reset = 1'b1;
        exp_idx++;
      end else if (out_valid) begin
        stalled = 1'b1;
        hold_i  = out_index;
        hold_d  = out_data;
      end
      if (issued - exp_idx > max_out) max_out = issued - exp_idx;
      if (done) begin
        done_cnt++;
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_cksum", 32'(checksum), 32'(ExpCkA));
      end
      if (done_cnt > 0) post++;
      tick;
      cyc++;
      if (hit_reset) begin
        rst = 1'b1;
        start = 1'b0;
        tick;
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        finished = 1'b1;
      end else if (post >= 5) begin
        finished = 1'b1;
      end
    end
    chk("drain_finished", 32'(finished), 32'd1);
    chk("max_outstanding_ok", 32'(max_out <= 2), 32'd1);
    if (reset_after >= 0) begin
      chk("words_before_reset", 32'(exp_idx), 32'(reset_after + 1));
      chk("done_pulses_reset", 32'(done_cnt), 32'd0);
    end else begin
      chk("words", 32'(exp_idx), 32'd16);
      chk("done_pulses", 32'(done_cnt), 32'd1);
    end
    out_ready = 1'b1;
    tick;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bw, bdone;
    for (int k = 0; k < 21; k++) begin
      vecs[k].start     = (k == 18);
      vecs[k].ready     = 1'b1;
      vecs[k].rd_en     = (k <= 15);
      vecs[k].rd_addr   = (k <= 15) ? 4'(k) : 4'd15;
      vecs[k].out_valid = (k >= 2 && k <= 17);
      vecs[k].out_index = 5'(k - 2);
      vecs[k].out_data  = 16'(3 * (k - 2) + 1);
      vecs[k].out_last  = (k == 17);
      vecs[k].busy      = (k <= 17);
      vecs[k].done      = (k == 18);
    end

    rst = 1'b1; start = 1'b0; out_ready = 1'b1; b_start = 1'b0; b_ready = 1'b1;
    tick; tick; tick;
    rst = 1'b0;
    #1;
    chk("rst_busy0", 32'(busy), 32'd0);
    chk("rst_done0", 32'(done), 32'd0);
    chk("rst_rd_en0", 32'(rd_en), 32'd0);
    chk("rst_valid0", 32'(out_valid), 32'd0);
    chk("rst_last0", 32'(out_last), 32'd0);
    chk("rst_addr0", 32'(rd_addr), 32'd0);
    chk("rst_data0", 32'(out_data), 32'd0);
    chk("rst_index0", 32'(out_index), 32'd0);
    chk("rst_cksum0", 32'(checksum), 32'd0);
    tick;

    // Basic drain against the cycle table; start in the done cycle must be ignored
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 21; k++) begin
      out_ready = vecs[k].ready;
      #1;
      chk($sformatf("t%0d_rd_en", k), 32'(rd_en), 32'(vecs[k].rd_en));
      chk($sformatf("t%0d_rd_addr", k), 32'(rd_addr), 32'(vecs[k].rd_addr));
      chk($sformatf("t%0d_valid", k), 32'(out_valid), 32'(vecs[k].out_valid));
      chk($sformatf("t%0d_last", k), 32'(out_last), 32'(vecs[k].out_last));
      chk($sformatf("t%0d_busy", k), 32'(busy), 32'(vecs[k].busy));
      chk($sformatf("t%0d_done", k), 32'(done), 32'(vecs[k].done));
      if (vecs[k].out_valid) begin
        chk($sformatf("t%0d_index", k), 32'(out_index), 32'(vecs[k].out_index));
        chk($sformatf("t%0d_data", k), 32'(out_data), 32'(vecs[k].out_data));
      end
      if (vecs[k].done) chk("t_cksum", 32'(checksum), 32'(ExpCkA));
      start = vecs[k].start;
      tick;
    end
    start = 1'b0;
    tick;

    drain(1'b1, -1, -1);   // backpressure 1,0,0,1
    drain(1'b0, 5, -1);    // second start at word 5
    drain(1'b0, -1, 7);    // reset after word 7
    drain(1'b0, -1, -1);   // clean rerun from index 0

    // Two elements per word, eight words
    bw = 0; bdone = 0;
    b_start = 1'b1;
    tick;
    b_start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (b_out_valid) begin
        chk("b_idx", 32'(b_out_index), 32'(bw));
        chk("b_lo", 32'(b_out_data[15:0]), 32'(2 * bw));
        chk("b_hi", 32'(b_out_data[31:16]), 32'(2 * bw + 1));
        chk("b_last", 32'(b_out_last), 32'(bw == 7));
        bw++;
      end
      if (b_done) begin
        bdone++;
        chk("b_cksum", 32'(b_checksum), 32'(ExpCkB));
      end
      tick;
    end
    chk("b_words", 32'(bw), 32'd8);
    chk("b_done_pulses", 32'(bdone), 32'd1);
    chk("b_idle", 32'(b_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
